fifo_read_logic: RTL and testbench
==================================

Name: fifo_read_logic

Overview:
Read-side pointer/flag controller for the async FIFO; mirror and downstream neighbour of the write-side controller.
- Consumes the write pointer (Gray, already through a 2-flop synchronizer into the read clock domain).
- Generates the RAM read address/strobe, the empty and almost-empty flags, and an occupancy count.
- Exports its own Gray read pointer for synchronization back to the write domain.

Parameters:
PTR_SZ, 2, RAM address width in bits; depth = 2**PTR_SZ; pointers are PTR_SZ+1 bits (MSB = wrap bit).
AEMPTY_THR, 1, ralmost_empty asserts when occupancy <= AEMPTY_THR (legal range 0..2**PTR_SZ-1).

Ports:
clk  input  1  read-domain clock, rising edge.
rst  input  1  asynchronous, active-low reset.
rinc  input  1  read request from consumer.
wq2_waddr  input  PTR_SZ+1  synchronized Gray write pointer.
read_en  output  1  RAM read strobe (combinational).
raddr  output  PTR_SZ  RAM read address (registered).
raddr_gray  output  PTR_SZ+1  Gray read pointer to the write-domain synchronizer (registered).
rempty  output  1  FIFO empty (registered).
ralmost_empty  output  1  occupancy <= AEMPTY_THR (registered).
rcount  output  PTR_SZ+1  occupancy, 0..2**PTR_SZ (registered).
runderflow  output  1  one-cycle pulse: rinc seen while rempty (registered).

Behaviour:
- Reset (rst low, async) forces:
  - rbin=0, raddr=0, raddr_gray=0, rcount=0.
  - rempty=1, ralmost_empty=1, runderflow=0.
  - state=IDLE.
  - Reset is honoured mid-operation; any read in flight is discarded.
- read_en = rinc & ~rempty, combinational.
  - Data for raddr is valid from the RAM in the same cycle read_en is high.
- Internal binary pointer rbin[PTR_SZ:0].
  - rbin_next = rbin + read_en, modulo 2**(PTR_SZ+1); natural wrap 2**(PTR_SZ+1)-1 -> 0.
  - rgray_next = (rbin_next >> 1) ^ rbin_next.
- On each clk edge:
  - rbin <= rbin_next.
  - raddr <= rbin_next[PTR_SZ-1:0].
  - raddr_gray <= rgray_next.
- Empty: rempty <= (rgray_next == wq2_waddr). Compare the full PTR_SZ+1 bits, wrap bit included.
- Occupancy:
  - wbin = Gray-to-binary of wq2_waddr (XOR prefix from MSB).
  - rcount <= (wbin - rbin_next) mod 2**(PTR_SZ+1).
  - ralmost_empty <= (count_next <= AEMPTY_THR).
- Underflow: runderflow <= rinc & rempty. Pointer does not move.
- FSM (2-bit), registered, for status/debug; outputs derived from the datapath above:
  - IDLE: post-reset, nothing received yet. -> READ when empty_next==0, else stay.
  - READ: data available. -> EMPTY when empty_next==1, else stay.
  - EMPTY: drained after activity. -> READ when empty_next==0, else stay.
  - Unused encoding -> IDLE.
- Latency:
  - A write becomes visible 2 rclk after the Gray pointer changes (synchronizer), plus 1 rclk for rempty to fall.
  - rempty rises in the same edge as the final read.
  - rempty is pessimistic (may lag real data) but never optimistic.
- Simultaneous events:
  - Read and wq2_waddr change in the same cycle: both are used in the same next-state computation.
  - Last-entry read with a concurrent pointer update: empty evaluates against the new wq2_waddr.
- Full occupancy: rcount = 2**PTR_SZ exactly when the wrap bits differ and the lower bits are equal. Reads are allowed.
- No latch inference; every output is fully assigned in every branch.

Decomposition:
- Shared package fifo_pkg holds:
  - read FSM state encodings IDLE=2'b00, READ=2'b01, EMPTY=2'b10.
  - function gray2bin and function bin2gray, parameterised by width.
  - The write-side controller uses the same encodings and functions.
- One sub-module: fifo_gray2bin (combinational, width PTR_SZ+1), reused by the write side for its own occupancy.

Test Plan:
(All with PTR_SZ=2, AEMPTY_THR=1.)
1. Reset:
   - Assert rst=0 mid-stream -> immediately rempty=1, ralmost_empty=1, raddr=0, raddr_gray=000, rcount=0, runderflow=0, read_en=0.
2. Single entry:
   - wq2_waddr=001 -> next edge rempty=0, rcount=1, ralmost_empty=1.
   - rinc=1 one cycle -> read_en=1 in that cycle; next edge raddr=1, raddr_gray=001, rempty=1, rcount=0.
3. Full:
   - wq2_waddr=110 (bin 4) -> rcount=4, ralmost_empty=0.
   - Four back-to-back reads -> read_en on all four cycles, raddr 0,1,2,3 then 0; rcount 3,2,1,0; ralmost_empty rises when rcount=1.
4. Wrap:
   - Pre-advance to rbin=6; wq2_waddr=000 (bin 8≡0) -> rcount=2.
   - Two reads -> raddr_gray 101->100->000, raddr 2->3->0, rempty=1.
5. Underflow:
   - rinc=1 held 3 cycles while rempty=1 -> read_en=0, raddr unchanged, runderflow=1 on each following edge.
   - runderflow falls one cycle after rinc drops.
6. Simultaneous:
   - rcount=1, rinc=1 in the same cycle wq2_waddr advances by one -> rempty stays 0, rcount stays 1, FSM stays READ.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO read/write pointer controllers.
package fifo_pkg;

  // Read-side FSM encodings, also used by the write-side controller.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    EMPTY = 2'b10
  } rd_state_t;

  // Widest pointer the helpers handle. Narrower pointers are zero-extended,
  // which does not change either conversion.
  localparam int GW_MAX = 32;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GW_MAX-1:0] gray2bin(input logic [GW_MAX-1:0] g);
    logic [GW_MAX-1:0] b;
    b[GW_MAX-1] = g[GW_MAX-1];
    for (int i = GW_MAX-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Binary to Gray.
  function automatic logic [GW_MAX-1:0] bin2gray(input logic [GW_MAX-1:0] b);
    return (b >> 1) ^ b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter, shared by both FIFO controllers.
module fifo_gray2bin #(
  parameter int W = 3
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each bit is the XOR reduction of the Gray bits from the MSB down to it.
  // This keeps every bit independent of the others, so there is no ripple loop.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/fifo_read_logic.sv
// Read-side pointer/flag controller for the async FIFO.
// Takes the write pointer after it has been synchronized into the read domain.
module fifo_read_logic
  import fifo_pkg::*;
#(
  parameter int PTR_SZ     = 2,
  parameter int AEMPTY_THR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rinc,
  input  logic [PTR_SZ:0]   wq2_waddr,
  output logic              read_en,
  output logic [PTR_SZ-1:0] raddr,
  output logic [PTR_SZ:0]   raddr_gray,
  output logic              rempty,
  output logic              ralmost_empty,
  output logic [PTR_SZ:0]   rcount,
  output logic              runderflow
);

  localparam int PW = PTR_SZ + 1;
  localparam int GW = GW_MAX;
  localparam logic [PTR_SZ:0] AE_THR = AEMPTY_THR[PTR_SZ:0];

  logic [PTR_SZ:0] rbin;
  logic [PTR_SZ:0] rbin_next;
  logic [PTR_SZ:0] rgray_next;
  logic [PTR_SZ:0] wbin;
  logic [PTR_SZ:0] count_next;
  logic            empty_next;
  rd_state_t       state;

  // The RAM strobe is gated by the registered empty flag. That flag is
  // pessimistic, so the controller never reads a slot that was not written.
  assign read_en = rinc & ~rempty;

  fifo_gray2bin #(.W(PW)) u_wq2_g2b (
    .gray (wq2_waddr),
    .bin  (wbin)
  );

  // The next pointer and the flags both use the write pointer of this cycle.
  // A concurrent read and write are therefore resolved in one step.
  always_comb begin
    rbin_next  = rbin + {{PTR_SZ{1'b0}}, read_en};
    rgray_next = PW'(bin2gray(GW'(rbin_next)));
    empty_next = (rgray_next == wq2_waddr);
    count_next = wbin - rbin_next;
  end

  // Pointer, address and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rbin          <= '0;
      raddr         <= '0;
      raddr_gray    <= '0;
      rcount        <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      runderflow    <= 1'b0;
    end else begin
      rbin          <= rbin_next;
      raddr         <= rbin_next[PTR_SZ-1:0];
      raddr_gray    <= rgray_next;
      rcount        <= count_next;
      rempty        <= empty_next;
      ralmost_empty <= (count_next <= AE_THR);
      runderflow    <= rinc & rempty;
    end
  end

  // Status FSM for debug. It tells "never filled" apart from "drained".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= empty_next ? IDLE  : READ;
        READ:    state <= empty_next ? EMPTY : READ;
        EMPTY:   state <= empty_next ? EMPTY : READ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_read_logic.sv
// Directed bench for fifo_read_logic (PTR_SZ=2, AEMPTY_THR=1).
module tb_fifo_read_logic;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       rinc;
  logic [2:0] wq2_waddr;
  logic       read_en;
  logic [1:0] raddr;
  logic [2:0] raddr_gray;
  logic       rempty;
  logic       ralmost_empty;
  logic [2:0] rcount;
  logic       runderflow;

  int n_chk  = 0;
  int n_pass = 0;

  fifo_read_logic #(.PTR_SZ(2), .AEMPTY_THR(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .rinc          (rinc),
    .wq2_waddr     (wq2_waddr),
    .read_en       (read_en),
    .raddr         (raddr),
    .raddr_gray    (raddr_gray),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rcount        (rcount),
    .runderflow    (runderflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // Advance one edge, then settle past it before the bench samples or drives.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the registered outputs in one call.
  task automatic chk_regs(input string tag, input logic [1:0] a, input logic [2:0] g,
                          input logic e, input logic ae, input logic [2:0] c,
                          input logic u);
    chk({tag, ".raddr"}, 32'(raddr), 32'(a));
    chk({tag, ".gray"},  32'(raddr_gray), 32'(g));
    chk({tag, ".empty"}, 32'(rempty), 32'(e));
    chk({tag, ".aempty"}, 32'(ralmost_empty), 32'(ae));
    chk({tag, ".count"}, 32'(rcount), 32'(c));
    chk({tag, ".uflow"}, 32'(runderflow), 32'(u));
  endtask

  initial begin
    rst = 1'b0; rinc = 1'b0; wq2_waddr = 3'b000;
    step(); step();
    rst = 1'b1;
    step();
    chk_regs("por", 2'd0, 3'b000, 1'b1, 1'b1, 3'd0, 1'b0);
    chk("por.state", 32'(dut.state), 32'(IDLE));

    // 1. Async reset mid-stream: two entries visible, read requested.
    wq2_waddr = 3'b011;
    step();
    chk("pre.count", 32'(rcount), 32'd2);
    chk("pre.state", 32'(dut.state), 32'(READ));
    rinc = 1'b1;
    rst  = 1'b0;
    #1;
    chk_regs("rst", 2'd0, 3'b000, 1'b1, 1'b1, 3'd0, 1'b0);
    chk("rst.read_en", 32'(read_en), 32'd0);
    chk("rst.state", 32'(dut.state), 32'(IDLE));
    rinc = 1'b0; wq2_waddr = 3'b000;
    step();
    rst = 1'b1;
    step();

    // 2. Single entry.
    wq2_waddr = 3'b001;
    step();
    chk_regs("one", 2'd0, 3'b000, 1'b0, 1'b1, 3'd1, 1'b0);
    rinc = 1'b1;
    #1;
    chk("one.read_en", 32'(read_en), 32'd1);
    step();
    rinc = 1'b0;
    chk_regs("one.rd", 2'd1, 3'b001, 1'b1, 1'b1, 3'd0, 1'b0);
    chk("one.state", 32'(dut.state), 32'(EMPTY));

    // 3. Full: start again from reset, then write four entries (pointer 4 = Gray 110).
    rst = 1'b0; #1; rst = 1'b1;
    wq2_waddr = 3'b110;
    step();
    chk_regs("full", 2'd0, 3'b000, 1'b0, 1'b0, 3'd4, 1'b0);
    rinc = 1'b1;
    #1;
    chk("full.re0", 32'(read_en), 32'd1);
    step();
    chk_regs("full.r1", 2'd1, 3'b001, 1'b0, 1'b0, 3'd3, 1'b0);
    chk("full.re1", 32'(read_en), 32'd1);
    step();
    chk_regs("full.r2", 2'd2, 3'b011, 1'b0, 1'b0, 3'd2, 1'b0);
    chk("full.re2", 32'(read_en), 32'd1);
    step();
    chk_regs("full.r3", 2'd3, 3'b010, 1'b0, 1'b1, 3'd1, 1'b0);
    chk("full.re3", 32'(read_en), 32'd1);
    step();
    rinc = 1'b0;
    chk_regs("full.r4", 2'd0, 3'b110, 1'b1, 1'b1, 3'd0, 1'b0);

    // 4. Wrap: advance rbin to 6, then the write pointer wraps to 0 (an offset of 8).
    wq2_waddr = 3'b101;
    step();
    chk("pre6.count", 32'(rcount), 32'd2);
    rinc = 1'b1;
    step(); step();
    rinc = 1'b0;
    chk_regs("at6", 2'd2, 3'b101, 1'b1, 1'b1, 3'd0, 1'b0);
    wq2_waddr = 3'b000;
    step();
    chk_regs("wrap", 2'd2, 3'b101, 1'b0, 1'b0, 3'd2, 1'b0);
    rinc = 1'b1;
    step();
    chk_regs("wrap.r1", 2'd3, 3'b100, 1'b0, 1'b1, 3'd1, 1'b0);
    step();
    rinc = 1'b0;
    chk_regs("wrap.r2", 2'd0, 3'b000, 1'b1, 1'b1, 3'd0, 1'b0);

    // 5. Underflow: hold rinc for three cycles while the FIFO is empty.
    rinc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("uf.read_en", 32'(read_en), 32'd0);
      step();
      chk("uf.pulse", 32'(runderflow), 32'd1);
      chk("uf.raddr", 32'(raddr), 32'd0);
      chk("uf.empty", 32'(rempty), 32'd1);
    end
    rinc = 1'b0;
    step();
    chk("uf.fall", 32'(runderflow), 32'd0);

    // 6. A read and a write pointer advance in the same cycle.
    wq2_waddr = 3'b001;
    step();
    chk("sim.pre.count", 32'(rcount), 32'd1);
    chk("sim.pre.state", 32'(dut.state), 32'(READ));
    rinc = 1'b1;
    wq2_waddr = 3'b011;
    step();
    rinc = 1'b0;
    chk_regs("sim", 2'd1, 3'b001, 1'b0, 1'b1, 3'd1, 1'b0);
    chk("sim.state", 32'(dut.state), 32'(READ));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
